ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, enable 0xF4, reset 0xFF) from the CPU to an attached keyboard over the same open-drain ps2c/ps2d lines already used by the scancode receiver. It sits in MemoryUnit next to the PS/2 receiver. It performs the request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device acknowledge. `busy` tells the receiver to ignore line activity while a transfer is in progress.

---
 rtl/ps2_host_tx.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Pulls the clock low to inhibit, issues the start bit, then shifts out
// eight data bits, odd parity and a stop bit on device-generated falling
// edges. After that it samples the device acknowledge and waits for the
// bus to go idle.
// Ports:
//   clk, nreset        system clock, synchronous active-low reset
//   ps2c_in, ps2d_in   raw (asynchronous) PS/2 clock/data line levels
//   ps2c_oe, ps2d_oe   1 = pull the corresponding open-drain line low
//   data, start        command byte and request (accepted only when idle)
//   busy, done, error  in-progress flag, end-of-transfer pulse, fail flag
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | lines released, waiting for start
// S_INHIBIT   | clock held low; start bit asserted on the last cycle
// S_REQ       | clock released, start bit driven, waiting for first fall
// S_DATA      | shifting data bits, parity, stop on each device fall
// S_ACK       | data released, sampling device acknowledge on next fall
// S_WAIT_IDLE | waiting for both lines high before reporting done
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // One counter serves both the inhibit length and the timeout, so size it
  // for the larger of the two. INHIBIT_CYCLES is expected to be at least 2.
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                                    TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       k_q, k_d;
  logic [7:0]       data_q, data_d;
  logic             c_s1_q, c_s1_d, c_s2_q, c_s2_d, c_prev_q, c_prev_d;
  logic             d_s1_q, d_s1_d, d_s2_q, d_s2_d;
  logic             ps2c_oe_q, ps2c_oe_d, ps2d_oe_q, ps2d_oe_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic             fall, parity, timed_state;

  assign fall   = c_prev_q & ~c_s2_q;
  assign parity = ~^data_q;
  assign timed_state = (state_q == S_REQ) || (state_q == S_DATA) ||
                       (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    k_d       = k_q;
    data_d    = data_q;
    ps2c_oe_d = 1'b0;
    ps2d_oe_d = ps2d_oe_q;
    done_d    = 1'b0;
    error_d   = error_q;
    c_s1_d    = ps2c_in;
    c_s2_d    = c_s1_q;
    c_prev_d  = c_s2_q;
    d_s1_d    = ps2d_in;
    d_s2_d    = d_s1_q;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        ps2d_oe_d = 1'b0;
        if (start) begin
          state_d   = S_INHIBIT;
          data_d    = data;
          error_d   = 1'b0;
          k_d       = '0;
          ps2c_oe_d = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          ps2d_oe_d = 1'b1;
        end else begin
          ps2c_oe_d = 1'b1;
          // start bit overlaps the final inhibit cycle
          ps2d_oe_d = (cnt_q == INH_PRE);
        end
      end
      S_REQ: begin
        if (fall) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          k_d       = 4'd1;
          ps2d_oe_d = ~data_q[0];
        end
      end
      S_DATA: begin
        if (fall) begin
          cnt_d = '0;
          k_d   = k_q + 4'd1;
          // k_q is the previous fall count, so it indexes the next bit
          if (k_q <= 4'd7) begin
            ps2d_oe_d = ~data_q[k_q[2:0]];
          end else if (k_q == 4'd8) begin
            ps2d_oe_d = ~parity;
          end else begin
            ps2d_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end
      end
      S_ACK: begin
        ps2d_oe_d = 1'b0;
        if (fall) begin
          cnt_d   = '0;
          state_d = S_WAIT_IDLE;
          if (d_s2_q) error_d = 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        ps2d_oe_d = 1'b0;
        if (fall) cnt_d = '0;
        if (c_s2_q && d_s2_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        ps2d_oe_d = 1'b0;
      end
    endcase

    if (timed_state && !fall && !done_d && cnt_q == TMO_LAST) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      error_d   = 1'b1;
      done_d    = 1'b1;
      ps2c_oe_d = 1'b0;
      ps2d_oe_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      data_q    <= '0;
      c_s1_q    <= 1'b1;
      c_s2_q    <= 1'b1;
      c_prev_q  <= 1'b1;
      d_s1_q    <= 1'b1;
      d_s2_q    <= 1'b1;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      data_q    <= data_d;
      c_s1_q    <= c_s1_d;
      c_s2_q    <= c_s2_d;
      c_prev_q  <= c_prev_d;
      d_s1_q    <= d_s1_d;
      d_s2_q    <= d_s2_d;
      ps2c_oe_q <= ps2c_oe_d;
      ps2d_oe_q <= ps2d_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ps2c_oe = ps2c_oe_q;
  assign ps2d_oe = ps2d_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device
// model driving the open-drain lines (16 clk per device clock period).
module tb_ps2_host_tx;
  localparam int INH  = 10;
  localparam int TMO  = 400;
  localparam int HALF = 8;

  logic       clk, nreset, start;
  logic [7:0] data;
  logic       ps2c_oe, ps2d_oe, busy, done, error;
  logic       bfm_c_low, bfm_d_low;
  logic       ps2c_in, ps2d_in;

  int          n_pass, n_total;
  int          hi, n;
  logic        d_last, d_prev;
  logic [10:0] cap;
  logic        s;

  assign ps2c_in = ~(ps2c_oe | bfm_c_low);
  assign ps2d_in = ~(ps2d_oe | bfm_d_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nreset(nreset), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .data(data), .start(start),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Counts consecutive samples with ps2c_oe high, remembering ps2d_oe in
  // the last two of them.
  task automatic measure_inhibit(output int h, output logic dl, output logic dp);
    h = 0; dl = 1'b0; dp = 1'b0;
    while (ps2c_oe === 1'b1 && h < 100) begin
      h++;
      dp = dl;
      dl = ps2d_oe;
      tick();
    end
  endtask

  // One device clock pulse; the line is sampled as the clock rises.
  task automatic bfm_pulse(output logic smp);
    bfm_c_low = 1'b1;
    repeat (HALF) tick();
    bfm_c_low = 1'b0;
    smp = ps2d_in;
    repeat (HALF) tick();
  endtask

  // Full device side of a frame: start, 8 data, parity, stop, ack pulse.
  // poke != 0 pulses start (with a different data byte) after that pulse.
  task automatic bfm_frame(input bit ack, input int poke, input bit hold,
                           input logic [7:0] hold_data, output logic [10:0] c);
    logic smp;
    repeat (4) tick();
    c[0] = ps2d_in;
    for (int i = 1; i <= 10; i++) begin
      bfm_pulse(smp);
      c[i] = smp;
      if (i == poke) begin
        start = 1'b1; data = 8'h00;
        tick();
        start = 1'b0;
      end
    end
    if (ack) bfm_d_low = 1'b1;
    tick();
    bfm_c_low = 1'b1;
    repeat (HALF) tick();
    bfm_c_low = 1'b0;
    tick();
    bfm_d_low = 1'b0;
    if (hold) begin
      start = 1'b1; data = hold_data;
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (done !== 1'b1 && cnt < 3000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    nreset = 1'b0; start = 1'b0; data = 8'h00;
    bfm_c_low = 1'b0; bfm_d_low = 1'b0;
    repeat (3) tick();
    chk("rst_ps2c_oe", ps2c_oe, 0);
    chk("rst_ps2d_oe", ps2d_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    nreset = 1'b1;
    tick();

    // 0xF4 with ack, parity 0
    data = 8'hF4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("f4_busy_start", busy, 1);
    chk("f4_ps2c_oe_start", ps2c_oe, 1);
    measure_inhibit(hi, d_last, d_prev);
    chk("f4_inhibit_len", hi, 10);
    chk("f4_d_last_inh", d_last, 1);
    chk("f4_d_prev_inh", d_prev, 0);
    chk("f4_req_d_oe", ps2d_oe, 1);
    bfm_frame(1'b1, 0, 1'b0, 8'h00, cap);
    chk("f4_start_bit", cap[0], 0);
    chk("f4_data", cap[8:1], 8'hF4);
    chk("f4_parity", cap[9], 0);
    chk("f4_stop", cap[10], 1);
    wait_done(n);
    chk("f4_done", done, 1);
    chk("f4_error", error, 0);
    chk("f4_busy_at_done", busy, 0);
    tick();
    chk("f4_done_width", done, 0);

    // 0xED, parity 1
    data = 8'hED; start = 1'b1;
    tick();
    start = 1'b0;
    measure_inhibit(hi, d_last, d_prev);
    chk("ed_inhibit_len", hi, 10);
    bfm_frame(1'b1, 0, 1'b0, 8'h00, cap);
    chk("ed_data", cap[8:1], 8'hED);
    chk("ed_parity", cap[9], 1);
    wait_done(n);
    chk("ed_done", done, 1);
    chk("ed_error", error, 0);
    tick();

    // 0xFF, parity 1
    data = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    measure_inhibit(hi, d_last, d_prev);
    bfm_frame(1'b1, 0, 1'b0, 8'h00, cap);
    chk("ff_data", cap[8:1], 8'hFF);
    chk("ff_parity", cap[9], 1);
    chk("ff_stop", cap[10], 1);
    wait_done(n);
    chk("ff_done", done, 1);
    chk("ff_error", error, 0);
    tick();

    // silent device: timeout 400 cycles after entering REQ
    data = 8'hF4; start = 1'b1;
    tick();
    start = 1'b0;
    measure_inhibit(hi, d_last, d_prev);
    wait_done(n);
    chk("tmo_cycles", n, 400);
    chk("tmo_done", done, 1);
    chk("tmo_error", error, 1);
    chk("tmo_ps2c_oe", ps2c_oe, 0);
    chk("tmo_ps2d_oe", ps2d_oe, 0);
    chk("tmo_busy", busy, 0);
    tick();

    // nack: data left high on the 11th edge
    data = 8'hF4; start = 1'b1;
    tick();
    start = 1'b0;
    chk("nack_error_cleared", error, 0);
    measure_inhibit(hi, d_last, d_prev);
    bfm_frame(1'b0, 0, 1'b0, 8'h00, cap);
    wait_done(n);
    chk("nack_done", done, 1);
    chk("nack_error", error, 1);
    repeat (3) tick();
    chk("nack_error_holds", error, 1);

    // reset in DATA at k=4, then a clean 0x55 transfer
    data = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    measure_inhibit(hi, d_last, d_prev);
    repeat (4) tick();
    for (int i = 0; i < 4; i++) bfm_pulse(s);
    chk("rstmid_d_oe_bit3", ps2d_oe, 1);
    nreset = 1'b0;
    tick();
    chk("rstmid_ps2c_oe", ps2c_oe, 0);
    chk("rstmid_ps2d_oe", ps2d_oe, 0);
    chk("rstmid_busy", busy, 0);
    nreset = 1'b1;
    tick();
    data = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    measure_inhibit(hi, d_last, d_prev);
    chk("x55_inhibit_len", hi, 10);
    bfm_frame(1'b1, 0, 1'b0, 8'h00, cap);
    chk("x55_start_bit", cap[0], 0);
    chk("x55_data", cap[8:1], 8'h55);
    chk("x55_parity", cap[9], 1);
    wait_done(n);
    chk("x55_done", done, 1);
    chk("x55_error", error, 0);
    tick();

    // start pulse mid-DATA ignored; start held across done re-triggers
    data = 8'h12; start = 1'b1;
    tick();
    start = 1'b0;
    measure_inhibit(hi, d_last, d_prev);
    bfm_frame(1'b1, 3, 1'b1, 8'h3C, cap);
    chk("poke_data", cap[8:1], 8'h12);
    chk("poke_parity", cap[9], 1);
    wait_done(n);
    chk("hold_done", done, 1);
    chk("hold_error", error, 0);
    chk("hold_ps2c_oe_at_done", ps2c_oe, 0);
    tick();
    chk("hold_ps2c_oe_next", ps2c_oe, 1);
    chk("hold_busy_next", busy, 1);
    start = 1'b0;
    measure_inhibit(hi, d_last, d_prev);
    chk("hold_inhibit_len", hi, 10);
    bfm_frame(1'b1, 0, 1'b0, 8'h00, cap);
    chk("hold_data", cap[8:1], 8'h3C);
    chk("hold_parity", cap[9], 1);
    wait_done(n);
    chk("hold2_done", done, 1);
    chk("hold2_error", error, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
